mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the fetch stage (read-only) and the mem stage (load/store).
//  - Only one transaction is outstanding at a time.
//  - Data requests win by default. A streak limit bounds how long fetch can be starved.
//  - Requesters see backpressure through req/gnt: gnt low acts as the stage stall. Responses return via rvalid.
//  - A branch flush discards an in-flight fetch response; data transactions are never dropped.
// PARAMETERS
//  ADDR_WIDTH       32  byte address width
//  DATA_WIDTH       32  data width; byte-enable width is DATA_WIDTH/8
//  MAX_DATA_STREAK  4   consecutive data grants allowed while if_req is pending (>=1)
// PORTS
//  clk        in   1      rising-edge clock, single clock domain
//  reset      in   1      synchronous, active-high
//  flush      in   1      branch flush from execute; kills the outstanding fetch response
//  if_req     in   1      fetch read request; held with stable if_addr until if_gnt
//  if_addr    in   AW     fetch byte address
//  if_gnt     out  1      fetch request accepted this cycle
//  if_rvalid  out  1      fetch read data valid
//  if_rdata   out  DW     fetch read data
//  d_req      in   1      data request; held stable until d_gnt
//  d_we       in   1      1 = store, 0 = load
//  d_be       in   DW/8   byte enables (stores)
//  d_addr     in   AW     data byte address
//  d_wdata    in   DW     store data
//  d_gnt      out  1      data request accepted this cycle
//  d_rvalid   out  1      load data valid / store acknowledge
//  d_rdata    out  DW     load data
//  mem_req    out  1      request to backing memory
//  mem_we     out  1      memory write
//  mem_be     out  DW/8   memory byte enables (all ones for fetch)
//  mem_addr   out  AW     memory address
//  mem_wdata  out  DW     memory write data (0 for fetch)
//  mem_gnt    in   1      memory accepts mem_req this cycle
//  mem_rvalid in   1      memory response; arrives >=1 cycle after mem_gnt
//  mem_rdata  in   DW     memory read data
//  proto_err  out  1      sticky: mem_rvalid seen while no transaction is outstanding
// BEHAVIOUR
//  - Reset: state=IDLE, streak=0, drop=0, proto_err=0.
//    All outputs 0 while reset=1, including combinational gnt/mem_req.
//  - States:
//    - IDLE: no transaction outstanding.
//    - WAIT_I: fetch transaction outstanding.
//    - WAIT_D: data transaction outstanding.
//  - IDLE, selection:
//    - If d_req and (!if_req or streak < MAX_DATA_STREAK): select D.
//    - Else if if_req: select I.
//    - Else: select none.
//  - IDLE, issue:
//    - mem_req = (selection != none); mem_* driven combinationally from the selected requester.
//    - Grant on mem_gnt: if_gnt/d_gnt = mem_gnt & selected. Next state is WAIT_I or WAIT_D.
//  - WAIT_x:
//    - mem_req=0; no new grants.
//    - On mem_rvalid: route mem_rdata to the owner; x_rvalid pulses for 1 cycle; next state = IDLE.
//    - The next grant is therefore at the earliest the cycle after the response (one bubble).
//  - Latency: grant-to-rvalid = memory latency; the arbiter adds 0 cycles on the response path.
//  - Streak counter:
//    - +1 on each d_gnt while if_req=1.
//    - Cleared on if_gnt, or in any cycle with if_req=0.
//    - Saturates at MAX_DATA_STREAK.
//  - Flush:
//    - drop<=1 if flush and (state==WAIT_I or if_gnt this cycle).
//    - While drop=1, the fetch response is consumed (state returns to IDLE) but if_rvalid stays 0.
//    - drop clears on that response.
//    - flush has no effect on WAIT_D, on d_*, or on an ungranted if_req.
//  - Simultaneous:
//    - flush with mem_rvalid in WAIT_I: response dropped.
//    - mem_rvalid in IDLE: ignored, proto_err<=1.
//  - Reset mid-transaction: FSM returns to IDLE. Any late mem_rvalid after reset release sets proto_err.
//    The memory is required to be reset in the same cycle.
// STRUCTURE
//  - common package additions:
//    - typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT_I, ARB_WAIT_D} arb_state_e;
//    - localparam ARB_MAX_DATA_STREAK = 4.
//  - Single module, no sub-module: one FSM, one streak counter, one drop flag, plus combinational muxes.
//  - Instantiated in cpu between fetch_stage/mem_stage and the unified memory.
//  - !if_gnt feeds PC_stall; !d_gnt / pending d_rvalid feeds the ex_mem and mem_wb stalls.
// TESTING
//  - Lone fetch: if_req=1, addr=0x100; mem_gnt=1 immediately, rvalid 2 cycles later with 0x00000013.
//    -> if_gnt at cycle 0, if_rvalid=1 with if_rdata=0x00000013 at cycle 2, mem_be=4'hF.
//  - Contention: if_req and d_req (store, be=4'b0011, addr=0x2000) in the same cycle.
//    -> d_gnt first, mem_we=1, mem_be=0011; fetch is granted the cycle after the store ack.
//  - Starvation: d_req held high (new requests back-to-back) with if_req high, MAX_DATA_STREAK=4.
//    -> exactly 4 d_gnt, then if_gnt, then data resumes.
//  - Flush: flush=1 one cycle after if_gnt, rvalid 3 cycles later.
//    -> if_rvalid stays 0, state returns to IDLE, next if_req is granted normally.
//  - Protocol/reset: reset asserted in WAIT_D, then mem_rvalid=1 after release.
//    -> d_rvalid=0, proto_err=1 and stays set until reset.
//  - Backpressure: mem_gnt=0 for 5 cycles with d_req held.
//    -> d_gnt=0 throughout, mem_addr stable, grant on the first cycle mem_gnt=1.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

  // Arbiter ownership of the single memory port
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_WAIT_I = 2'd1,
    ARB_WAIT_D = 2'd2
  } arb_state_e;

  // Consecutive data grants tolerated while a fetch is waiting
  localparam int ARB_MAX_DATA_STREAK = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (read-only) and data (load/store), one transaction in flight.
// Latency: request to mem_req is combinational; the response is forwarded combinationally (0 added cycles).
// Backpressure: gnt follows mem_gnt for the selected requester only; no new grant while a response is pending.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = ARB_MAX_DATA_STREAK
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    proto_err
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          drop_q, drop_d;
  logic          proto_err_q, proto_err_d;

  logic sel_i, sel_d;   // requester driving the memory port this cycle
  logic resp_i, resp_d; // memory response belongs to fetch / data

  // Next-state logic and requester selection; everything is forced idle during reset
  always_comb begin
    state_d = state_q;
    sel_i   = 1'b0;
    sel_d   = 1'b0;
    resp_i  = 1'b0;
    resp_d  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (d_req && (!if_req || (streak_q < STREAK_MAX))) begin
          sel_d = 1'b1;
        end else if (if_req) begin
          sel_i = 1'b1;
        end
        if (mem_gnt && sel_d) begin
          state_d = ARB_WAIT_D;
        end else if (mem_gnt && sel_i) begin
          state_d = ARB_WAIT_I;
        end
      end
      ARB_WAIT_I: begin
        if (mem_rvalid) begin
          resp_i  = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      ARB_WAIT_D: begin
        if (mem_rvalid) begin
          resp_d  = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    if (reset) begin
      sel_i   = 1'b0;
      sel_d   = 1'b0;
      resp_i  = 1'b0;
      resp_d  = 1'b0;
      state_d = ARB_IDLE;
    end
  end

  // Port muxes: the selected requester drives the memory, responses go to the owner
  always_comb begin
    mem_req   = sel_i | sel_d;
    mem_we    = sel_d & d_we;
    mem_be    = sel_d ? d_be : (sel_i ? '1 : '0);
    mem_addr  = sel_d ? d_addr : (sel_i ? if_addr : '0);
    mem_wdata = sel_d ? d_wdata : '0;
    if_gnt    = sel_i & mem_gnt;
    d_gnt     = sel_d & mem_gnt;
    // A flush arriving together with the response kills it as well
    if_rvalid = resp_i & ~drop_q & ~flush;
    if_rdata  = resp_i ? mem_rdata : '0;
    d_rvalid  = resp_d;
    d_rdata   = resp_d ? mem_rdata : '0;
    proto_err = proto_err_q & ~reset;
  end

  // Streak, drop and protocol-error next values
  always_comb begin
    streak_d = streak_q;
    if (!if_req || if_gnt) begin
      streak_d = '0;
    end else if (d_gnt && (streak_q < STREAK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end

    drop_d = drop_q;
    if (resp_i) begin
      // The killed response has been consumed; the next fetch is clean
      drop_d = 1'b0;
    end else if (flush && ((state_q == ARB_WAIT_I) || if_gnt)) begin
      drop_d = 1'b1;
    end

    proto_err_d = proto_err_q;
    if ((state_q == ARB_IDLE) && mem_rvalid) begin
      proto_err_d = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Streak counter, drop flag and sticky protocol error
  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q    <= '0;
      drop_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      streak_q    <= streak_d;
      drop_q      <= drop_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule
